// File: rtl/operand_sequencer.sv
// Packs a 32-bit operand word stream into the datapath operand vector, holds it for
// a settle window, captures the result and returns it over valid/ready with a running XOR signature.
module operand_sequencer #(
  parameter int IN_W   = 171,
  parameter int OUT_W  = 24,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic [IN_W-1:0]   op_vec,
  input  logic [OUT_W-1:0]  dut_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic [OUT_W-1:0]  sig,
  output logic [15:0]       vec_count
);

  localparam int NWORDS = (IN_W + 31) / 32;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IN_W-1:0]   op_vec_q, op_vec_d;
  logic              res_valid_q, res_valid_d;
  logic [OUT_W-1:0]  res_data_q, res_data_d;
  logic [OUT_W-1:0]  sig_q, sig_d;
  logic [15:0]       vec_count_q, vec_count_d;

  logic              word_fire;
  logic [NWORDS-1:0] word_we;
  logic              unused_in_data;

  // Bits of the final word above IN_W-1 have nowhere to go.
  assign unused_in_data = ^in_data;

  // Ready depends only on registered state and reset, never on in_valid.
  assign in_ready  = (state_q == ST_LOAD) && !rst;
  assign word_fire = (state_q == ST_LOAD) && in_valid && !abort;

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
    localparam int LO = gi * 32;
    localparam int HI = (LO + 31 > IN_W - 1) ? IN_W - 1 : LO + 31;
    assign word_we[gi] = word_fire && (k_q == KW'(gi));
    assign op_vec_d[HI:LO] = word_we[gi] ? in_data[HI-LO:0] : op_vec_q[HI:LO];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    sig_d       = sig_q;
    vec_count_d = vec_count_q;
    if (abort) begin
      // Abort wins over any handshake in the same cycle.
      k_d         = '0;
      res_valid_d = 1'b0;
      state_d     = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            if (k_q == KW'(NWORDS - 1)) begin
              k_d     = '0;
              cnt_d   = CW'(SETTLE - 1);
              state_d = ST_WAIT;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            res_data_d  = dut_y;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            sig_d       = sig_q ^ res_data_q;
            vec_count_d = vec_count_q + 16'd1;
            res_valid_d = 1'b0;
            state_d     = ST_LOAD;
          end
        end
        default: begin
          k_d         = '0;
          res_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      k_q         <= '0;
      cnt_q       <= '0;
      op_vec_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      sig_q       <= '0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      op_vec_q    <= op_vec_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      sig_q       <= sig_d;
      vec_count_q <= vec_count_d;
    end
  end

  assign op_vec    = op_vec_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign sig       = sig_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer; the datapath is modelled as dut_y = op_vec[23:0].
module tb_operand_sequencer;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [170:0]  op_vec;
  logic [23:0]   dut_y;
  logic          res_valid;
  logic          res_ready;
  logic [23:0]   res_data;
  logic [23:0]   sig;
  logic [15:0]   vec_count;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [23:0]   sb_q[$];
  logic [23:0]   model_sig = '0;
  logic [15:0]   model_cnt = '0;
  logic [23:0]   exp_v;

  always #5 clk = ~clk;

  operand_sequencer #(.IN_W(171), .OUT_W(24), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .op_vec(op_vec), .dut_y(dut_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .sig(sig), .vec_count(vec_count)
  );

  assign dut_y = op_vec[23:0];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result monitor: pops the scoreboard on every effective result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_valid_excl", 64'(in_ready && res_valid), 64'd0);
      if (res_valid && res_ready && !abort) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          exp_v = sb_q.pop_front();
          chk("res_data", 64'(res_data), 64'(exp_v));
          model_sig = model_sig ^ exp_v;
          model_cnt = model_cnt + 16'd1;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("word_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [31:0] w0, w1, w2, w3, w4, w5, input bit push);
    if (push) sb_q.push_back(w0[23:0]);
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(w3);
    send_word(w4);
    send_word(w5);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("res_timeout", 64'(res_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_sig = '0;
    model_cnt = '0;
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    abort     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    res_ready = 1'b1;

    // Reset held with in_valid high: nothing accepted, all outputs zero.
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_op_vec_nz", 64'(op_vec != '0), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_sig", 64'(sig), 64'd0);
      chk("rst_vec_count", 64'(vec_count), 64'd0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_op_vec_nz", 64'(op_vec != '0), 64'd0);

    // Single vector with backpressure.
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    send_vec(32'h00AB_CDEF, 0, 0, 0, 0, 0, 1'b1);
    chk("lat_early", 64'(res_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(res_valid), 64'd1);
    chk("lat_data", 64'(res_data), 64'hAB_CDEF);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_data", 64'(res_data), 64'hAB_CDEF);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_sig", 64'(sig), 64'hAB_CDEF);
    chk("bp_vec_count", 64'(vec_count), 64'd1);
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_valid_after", 64'(res_valid), 64'd0);

    // Truncation of the final word.
    send_vec(0, 0, 0, 0, 32'hE000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("trunc_top", 64'(op_vec[170:157]), 64'h3FFF);
    chk("trunc_mid", 64'(op_vec[156:128]), 64'd0);
    chk("trunc_no_x", 64'($isunknown(op_vec)), 64'd0);
    wait_done();
    chk("trunc_sig", 64'(sig), 64'(model_sig));
    chk("trunc_vec_count", 64'(vec_count), 64'd2);

    // Abort mid-load, then one complete vector.
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_sig", 64'(sig), 64'(model_sig));
    chk("abort_vec_count", 64'(vec_count), 64'(model_cnt));
    send_vec(32'h0077_7777, 1, 2, 3, 4, 5, 1'b1);
    wait_done();
    repeat (3) begin
      @(negedge clk);
      chk("abort_one_result", 64'(res_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
    end
    chk("abort_vec_count2", 64'(vec_count), 64'd3);
    chk("abort_sb_empty", 64'(sb_q.size()), 64'd0);

    // Signature cancellation from a fresh reset.
    do_reset(2);
    send_vec(32'h0012_3456, 32'hDEAD_BEEF, 0, 0, 0, 0, 1'b1);
    wait_done();
    send_vec(32'h0012_3456, 0, 32'h5555_5555, 0, 0, 7, 1'b1);
    wait_done();
    chk("cancel_sig", 64'(sig), 64'd0);
    chk("cancel_vec_count", 64'(vec_count), 64'd2);

    // Abort coinciding with the result handshake in HOLD.
    res_ready = 1'b0;
    send_vec(32'h00AB_CDEF, 0, 0, 0, 0, 0, 1'b0);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 50) begin
        n++;
        @(negedge clk);
      end
      chk("hold_reached", 64'(res_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_hs_vec_count", 64'(vec_count), 64'd2);
    chk("abort_hs_sig", 64'(sig), 64'd0);
    chk("abort_hs_valid", 64'(res_valid), 64'd0);
    chk("abort_hs_in_ready", 64'(in_ready), 64'd1);

    // Reset asserted during WAIT.
    send_vec(32'h0055_5555, 0, 0, 0, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_valid", 64'(res_valid), 64'd0);
      chk("rstw_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_sig = '0;
    model_cnt = '0;
    sb_q.delete();
    @(negedge clk);
    chk("rstw_op_vec_nz", 64'(op_vec != '0), 64'd0);
    chk("rstw_in_ready_after", 64'(in_ready), 64'd1);
    chk("rstw_valid_after", 64'(res_valid), 64'd0);
    chk("rstw_vec_count", 64'(vec_count), 64'd0);
    @(posedge clk);
    #1;
    send_vec(32'h0024_6813, 9, 8, 7, 6, 5, 1'b1);
    wait_done();
    chk("rstw_final_count", 64'(vec_count), 64'd1);
    chk("rstw_final_sig", 64'(sig), 64'h24_6813);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
